karin_result_capture: RTL and testbench

- Synchronous initiator/collector for Karin asynchronous bundled-data blocks, e.g. the async comparator.
- Raises req to the async block and synchronises its fin response into the clk domain.
- Captures the bundled result, then completes a four-phase return-to-zero handshake.
- Reports the measured handshake latency in clock cycles, so sync-vs-async speed tests are self-timed in hardware.

---
 rtl/karin_pkg.sv | 15 +
 rtl/karin_sync.sv | 23 ++
 rtl/karin_result_capture.sv | 169 ++++++++++++++++
 tb/tb_karin_result_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/karin_pkg.sv
// Shared types and default constants for the Karin result-capture block.
package karin_pkg;

    localparam int KARIN_SYNC_STAGES = 2;
    localparam int KARIN_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_HI   = 3'd1,
        CAPTURE  = 3'd2,
        CAPTURE2 = 3'd3,
        REQ_LO   = 3'd4
    } karin_state_e;

endpackage

// File: rtl/karin_sync.sv
// N-stage synchroniser for a single asynchronous level; synchronous reset clears all stages.
module karin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/karin_result_capture.sv
// Four-phase initiator/collector for a bundled-data async block, with latency measurement.
// Optional KARIN_BUNDLE_CHECK_EN adds a second capture cycle that flags unstable bundled data.
module karin_result_capture
    import karin_pkg::*;
#(
    parameter int DATA_W      = 3,
    parameter int SYNC_STAGES = KARIN_SYNC_STAGES,
    parameter int CNT_W       = KARIN_CNT_W,
    parameter int TIMEOUT     = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              req_out,
    input  logic              fin_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  latency,
    output logic              timeout_err,
    output logic              bundle_err,
    output karin_state_e      state_dbg
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Handshake: req_out rises from IDLE, fin is observed only through fin_sync,
    // and req_out falls once the result is captured (or the phase times out).
    karin_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic              tout_q, tout_d;
    logic              done_c;
    logic              fin_sync;

    karin_sync #(
        .STAGES (SYNC_STAGES)
    ) u_fin_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (fin_in),
        .sync_o  (fin_sync)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef KARIN_BUNDLE_CHECK_EN
    logic berr_q, berr_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lat_d   = lat_q;
        tout_d  = tout_q;
        done_c  = 1'b0;
`ifdef KARIN_BUNDLE_CHECK_EN
        berr_d  = berr_q;
`endif
        case (state_q)
            IDLE: begin
                // A fin still high from a previous or aborted transaction blocks launch.
                if (start && !fin_sync) begin
                    state_d = REQ_HI;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
`ifdef KARIN_BUNDLE_CHECK_EN
                    berr_d  = 1'b0;
`endif
                end
            end
            REQ_HI: begin
                cnt_d = cnt_inc;
                if (fin_sync) begin
                    state_d = CAPTURE;
                    lat_d   = cnt_inc;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = REQ_LO;
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                data_d = data_in;
                cnt_d  = '0;
`ifdef KARIN_BUNDLE_CHECK_EN
                state_d = CAPTURE2;
`else
                req_d   = 1'b0;
                state_d = REQ_LO;
`endif
            end
            CAPTURE2: begin
`ifdef KARIN_BUNDLE_CHECK_EN
                if (data_in != data_q) begin
                    berr_d = 1'b1;
                    data_d = data_in;
                end
`endif
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = REQ_LO;
            end
            REQ_LO: begin
                cnt_d = cnt_inc;
                if (!fin_sync) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            tout_q  <= tout_d;
        end
    end

`ifdef KARIN_BUNDLE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            berr_q <= 1'b0;
        end else begin
            berr_q <= berr_d;
        end
    end
    assign bundle_err = berr_q;
`else
    assign bundle_err = 1'b0;
`endif

    // done is asserted in the last non-IDLE cycle, so a start in that cycle is dropped.
    assign done        = done_c;
    assign busy        = (state_q != IDLE);
    assign req_out     = req_q;
    assign data_out    = data_q;
    assign latency     = lat_q;
    assign timeout_err = tout_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_karin_result_capture.sv
// Directed bench for karin_result_capture: instant, delayed, timeout, reset and bundle-check cases.
module tb_karin_result_capture;
    import karin_pkg::*;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 16;
`ifdef KARIN_BUNDLE_CHECK_EN
    localparam int REQ_HI_CYCLES = 5;
`else
    localparam int REQ_HI_CYCLES = 4;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              req_out;
    logic              fin_in;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  latency;
    logic              timeout_err;
    logic              bundle_err;
    karin_state_e      state_dbg;

    int n_tests;
    int n_fail;

    // Responder modes: 0 = fin follows req, 1 = fin delayed 10 cycles, 2 = fin forced.
    int   resp_mode;
    logic fin_dly;
    logic fin_force;
    int   dcnt;

    karin_result_capture #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .req_out     (req_out),
        .fin_in      (fin_in),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .latency     (latency),
        .timeout_err (timeout_err),
        .bundle_err  (bundle_err),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fin_in = (resp_mode == 0) ? req_out :
                    (resp_mode == 1) ? fin_dly : fin_force;

    always @(posedge clk) begin
        if (!req_out) begin
            dcnt    <= 0;
            fin_dly <= 1'b0;
        end else begin
            dcnt    <= dcnt + 1;
            fin_dly <= (dcnt + 1 >= 10);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic count_req(output int n);
        n = 0;
        while (req_out && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nreq;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        data_in   = 3'b000;
        resp_mode = 0;
        fin_force = 1'b0;
        tick(3);

        chk("rst_req", {31'd0, req_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {29'd0, data_out}, 32'd0);
        chk("rst_lat", {16'd0, latency}, 32'd0);
        chk("rst_tout", {31'd0, timeout_err}, 32'd0);
        chk("rst_berr", {31'd0, bundle_err}, 32'd0);
        chk("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
        rst = 1'b0;
        tick(2);

        // Instant responder.
        data_in = 3'b100;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        count_req(nreq);
        chk("t1_req_cycles", nreq, REQ_HI_CYCLES);
        wait_done();
        chk("t1_data", {29'd0, data_out}, 32'd4);
        chk("t1_lat", {16'd0, latency}, 32'd3);
        chk("t1_busy_at_done", {31'd0, busy}, 32'd1);
        tick(1);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Responder delayed by 10 cycles.
        resp_mode = 1;
        data_in   = 3'b010;
        tick(1);
        pulse_start();
        wait_done();
        chk("t2_lat", {16'd0, latency}, 32'd13);
        chk("t2_tout", {31'd0, timeout_err}, 32'd0);
        chk("t2_data", {29'd0, data_out}, 32'd2);
        tick(1);
        chk("t2_idle", {29'd0, state_dbg}, {29'd0, IDLE});

        // fin never rises: timeout after 20 cycles.
        resp_mode = 2;
        fin_force = 1'b0;
        data_in   = 3'b111;
        tick(1);
        pulse_start();
        count_req(nreq);
        chk("t3_req_cycles", nreq, 20);
        wait_done();
        chk("t3_tout", {31'd0, timeout_err}, 32'd1);
        chk("t3_data_kept", {29'd0, data_out}, 32'd2);
        chk("t3_lat_kept", {16'd0, latency}, 32'd13);
        tick(1);
        chk("t3_tout_sticky", {31'd0, timeout_err}, 32'd1);
        resp_mode = 0;
        data_in   = 3'b101;
        pulse_start();
        chk("t3_tout_clear", {31'd0, timeout_err}, 32'd0);
        wait_done();
        chk("t3_data_next", {29'd0, data_out}, 32'd5);
        tick(1);

        // Reset during REQ_HI while the responder is raising fin.
        resp_mode = 2;
        fin_force = 1'b0;
        pulse_start();
        tick(2);
        fin_force = 1'b1;
        tick(1);
        chk("t4_in_req_hi", {29'd0, state_dbg}, {29'd0, REQ_HI});
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t4_req", {31'd0, req_out}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_data", {29'd0, data_out}, 32'd0);
        chk("t4_lat", {16'd0, latency}, 32'd0);
        tick(3);
        pulse_start();
        chk("t4_stale_ignored", {31'd0, busy}, 32'd0);
        fin_force = 1'b0;
        tick(3);
        resp_mode = 0;
        data_in   = 3'b011;
        pulse_start();
        chk("t4_accept", {31'd0, busy}, 32'd1);
        wait_done();
        chk("t4_lat_after", {16'd0, latency}, 32'd3);
        chk("t4_data_after", {29'd0, data_out}, 32'd3);
        tick(1);

        // start while busy and in the done cycle is dropped; one cycle later it launches.
        data_in = 3'b110;
        pulse_start();
        pulse_start();
        wait_done();
        chk("t5_data", {29'd0, data_out}, 32'd6);
        start = 1'b1;
        @(negedge clk);
        chk("t5_done_start_dropped", {31'd0, busy}, 32'd0);
        chk("t5_done_low", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("t5_relaunch", {31'd0, busy}, 32'd1);
        wait_done();
        tick(1);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Bundled data changes between the two capture samples.
        data_in = 3'b001;
        pulse_start();
        tick(4);
        data_in = 3'b100;
        wait_done();
`ifdef KARIN_BUNDLE_CHECK_EN
        chk("t6_berr", {31'd0, bundle_err}, 32'd1);
        chk("t6_data", {29'd0, data_out}, 32'd4);
`else
        chk("t6_berr", {31'd0, bundle_err}, 32'd0);
        chk("t6_data", {29'd0, data_out}, 32'd1);
`endif
        tick(1);
        pulse_start();
        chk("t6_berr_clear", {31'd0, bundle_err}, 32'd0);
        wait_done();
        chk("t6_data_stable", {29'd0, data_out}, 32'd4);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
